nzr_frame_ctrl: RTL and testbench

NZR_FRAME_CTRL -- requirements
Module: nzr_frame_ctrl

---
 rtl/nzr_frame_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_nzr_frame_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nzr_frame_ctrl.sv
// nzr_frame_ctrl: frame sequencer for an NZR (WS281x-style) LED chain.
// Reads GRB pixels from a pixel memory, feeds one line-code mode per bit to
// an external NZR bit generator, then holds the line low for RESET_BITS bit
// times before signalling frame_done.
//
// Optional feature: define NZR_AUTO_REFRESH_EN to restart the next frame
// directly from LATCH without waiting for another start pulse.
//
// Pixel read handshake: pix_rd is a one-cycle strobe with pix_addr valid in
// the same cycle; the memory returns pix_data exactly one cycle later, with
// no backpressure. At most one read is issued per pixel.

module nzr_frame_ctrl #(
  parameter int NUM_LEDS   = 8,
  parameter int RESET_BITS = 220
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  pix_addr,
  output logic        pix_rd,
  input  logic [23:0] pix_data,
  input  logic        bdone,
  output logic [1:0]  qmode,
  output logic        startcoding,
  output logic        busy,
  output logic        frame_done
);

  // Line-code modes understood by the bit generator.
  localparam logic [1:0] QM_ZERO = 2'b00;
  localparam logic [1:0] QM_ONE  = 2'b01;
  localparam logic [1:0] QM_LOW  = 2'b10;

  localparam logic [7:0] LAST_PIX   = 8'(NUM_LEDS - 1);
  localparam logic [7:0] LAST_LATCH = 8'(RESET_BITS - 1);
  localparam logic [4:0] LAST_BIT   = 5'd23;
  localparam bit         MULTI_PIX  = (NUM_LEDS > 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    SEND  = 3'd3,
    LATCH = 3'd4
  } state_t;

  // Current FSM state; kept as a named enum so it is easy to probe.
  state_t      state_q, state_d;

  logic [23:0] shreg_q, shreg_d;   // pixel being shifted out, MSB first
  logic [23:0] nbuf_q,  nbuf_d;    // prefetched next pixel
  logic [4:0]  bit_q,   bit_d;     // bit index within pixel (0..23)
  logic [7:0]  pix_q,   pix_d;     // pixel index within frame
  logic [7:0]  lcnt_q,  lcnt_d;    // bdone pulses counted in LATCH
  logic [1:0]  qmode_q, qmode_d;
  logic        rd_q,    rd_d;
  logic [7:0]  addr_q,  addr_d;
  logic        rd_pend_q;          // read issued last cycle, data valid now

  logic        latch_last;
  logic [7:0]  pix_next;

  assign latch_last = (lcnt_q == LAST_LATCH);
  assign pix_next   = pix_q + 8'd1;

  // Outputs that follow directly from the state register.
  assign qmode       = qmode_q;
  assign pix_rd      = rd_q;
  assign pix_addr    = addr_q;
  assign busy        = (state_q != IDLE);
  assign startcoding = (state_q == LOAD);
  assign frame_done  = (state_q == LATCH) && bdone && latch_last;

  // State and datapath registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      nbuf_q    <= '0;
      bit_q     <= '0;
      pix_q     <= '0;
      lcnt_q    <= '0;
      qmode_q   <= QM_LOW;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      nbuf_q    <= nbuf_d;
      bit_q     <= bit_d;
      pix_q     <= pix_d;
      lcnt_q    <= lcnt_d;
      qmode_q   <= qmode_d;
      rd_q      <= rd_d;
      addr_q    <= addr_d;
      rd_pend_q <= rd_q;
    end
  end

  // Next-state and next-register logic for the frame sequencer.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    nbuf_d  = nbuf_q;
    bit_d   = bit_q;
    pix_d   = pix_q;
    lcnt_d  = lcnt_q;
    qmode_d = qmode_q;
    rd_d    = 1'b0;
    addr_d  = addr_q;

    // Prefetch data returns one cycle after the strobe, while in SEND.
    if ((state_q == SEND) && rd_pend_q) begin
      nbuf_d = pix_data;
    end

    case (state_q)
      IDLE: begin
        qmode_d = QM_LOW;
        if (start) begin
          state_d = FETCH;
          rd_d    = 1'b1;
          addr_d  = 8'd0;
        end
      end

      FETCH: begin
        // Pixel 0 read is in flight; data arrives in LOAD.
        state_d = LOAD;
      end

      LOAD: begin
        // startcoding is high this cycle, so the generator counter restarts
        // exactly when the first bit mode becomes visible.
        shreg_d = pix_data;
        qmode_d = {1'b0, pix_data[23]};
        bit_d   = 5'd0;
        pix_d   = 8'd0;
        lcnt_d  = 8'd0;
        state_d = SEND;
        if (MULTI_PIX) begin
          rd_d   = 1'b1;
          addr_d = 8'd1;
        end
      end

      SEND: begin
        if (bdone) begin
          if (bit_q == LAST_BIT) begin
            if (pix_q == LAST_PIX) begin
              qmode_d = QM_LOW;
              lcnt_d  = 8'd0;
              state_d = LATCH;
            end else begin
              // Seamless hand-over to the prefetched pixel, no gap bit.
              shreg_d = nbuf_q;
              qmode_d = {1'b0, nbuf_q[23]};
              bit_d   = 5'd0;
              pix_d   = pix_next;
              if (pix_next < LAST_PIX) begin
                rd_d   = 1'b1;
                addr_d = pix_q + 8'd2;
              end
            end
          end else begin
            shreg_d = {shreg_q[22:0], 1'b0};
            qmode_d = shreg_q[22] ? QM_ONE : QM_ZERO;
            bit_d   = bit_q + 5'd1;
          end
        end
      end

      LATCH: begin
        qmode_d = QM_LOW;
        if (bdone) begin
          if (latch_last) begin
            lcnt_d = 8'd0;
            bit_d  = 5'd0;
            pix_d  = 8'd0;
`ifdef NZR_AUTO_REFRESH_EN
            state_d = FETCH;
            rd_d    = 1'b1;
            addr_d  = 8'd0;
`else
            state_d = IDLE;
            addr_d  = 8'd0;
`endif
          end else begin
            lcnt_d = lcnt_q + 8'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        qmode_d = QM_LOW;
      end
    endcase
  end

endmodule

// File: tb/tb_nzr_frame_ctrl.sv
// tb_nzr_frame_ctrl: directed bench for nzr_frame_ctrl with a free-running
// bit generator model, a pixel memory model and a per-bit qmode scoreboard.
// Instance A: NUM_LEDS=2, RESET_BITS=4.  Instance B: NUM_LEDS=1, RESET_BITS=4.

module tb_nzr_frame_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT A ----------------
  logic        start_a;
  logic [7:0]  pix_addr_a;
  logic        pix_rd_a;
  logic [23:0] pix_data_a = '0;
  logic        bdone_a;
  logic [1:0]  qmode_a;
  logic        sc_a, busy_a, fd_a;

  nzr_frame_ctrl #(.NUM_LEDS(2), .RESET_BITS(4)) dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .pix_addr(pix_addr_a), .pix_rd(pix_rd_a), .pix_data(pix_data_a),
    .bdone(bdone_a), .qmode(qmode_a), .startcoding(sc_a),
    .busy(busy_a), .frame_done(fd_a)
  );

  // ---------------- DUT B ----------------
  logic        start_b;
  logic [7:0]  pix_addr_b;
  logic        pix_rd_b;
  logic [23:0] pix_data_b = '0;
  logic        bdone_b;
  logic [1:0]  qmode_b;
  logic        sc_b, busy_b, fd_b;

  nzr_frame_ctrl #(.NUM_LEDS(1), .RESET_BITS(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .pix_addr(pix_addr_b), .pix_rd(pix_rd_b), .pix_data(pix_data_b),
    .bdone(bdone_b), .qmode(qmode_b), .startcoding(sc_b),
    .busy(busy_b), .frame_done(fd_b)
  );

  // ---------------- bit generator + pixel memory models ----------------
  logic [6:0]  bcnt_a = '0, bcnt_b = '0;
  logic [23:0] mem_a [0:3];
  logic [23:0] mem_b [0:3];

  assign bdone_a = (bcnt_a == 7'd127);
  assign bdone_b = (bcnt_b == 7'd127);

  always @(posedge clk) begin
    bcnt_a <= sc_a ? 7'd0 : bcnt_a + 7'd1;
    bcnt_b <= sc_b ? 7'd0 : bcnt_b + 7'd1;
    pix_data_a <= pix_rd_a ? mem_a[pix_addr_a[1:0]] : 24'hA5A5A5;
    pix_data_b <= pix_rd_b ? mem_b[pix_addr_b[1:0]] : 24'hA5A5A5;
  end

  // ---------------- scoreboard ----------------
  logic [1:0] exp_qa[$];
  logic [1:0] exp_qb[$];
  int rd_addr_a[$], rd_cyc_a[$], rd_addr_b[$], rd_cyc_b[$];
  int sc_n_a, sc_n_b, fd_n_a, fd_n_b;
  bit armed_a = 0, pend_a = 0, armed_b = 0, pend_b = 0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Each new bit period's qmode is compared against the next queued entry.
  always @(negedge clk) begin
    logic [1:0] ev;
    if (pend_a) begin
      pend_a = 0;
      if (exp_qa.size() > 0) begin
        ev = exp_qa.pop_front();
        chk("qmode_a", 32'(qmode_a), 32'(ev));
      end
    end
    if (sc_a) begin armed_a = 1; pend_a = 1; sc_n_a++; end
    else if (armed_a && bdone_a) pend_a = 1;
    if (exp_qa.size() == 0) armed_a = 0;
    if (pix_rd_a) begin
      rd_addr_a.push_back(int'(pix_addr_a));
      rd_cyc_a.push_back(cyc);
      chk("rd_addr_range_a", 32'(pix_addr_a < 8'd2), 32'd1);
    end
    if (fd_a) fd_n_a++;

    if (pend_b) begin
      pend_b = 0;
      if (exp_qb.size() > 0) begin
        ev = exp_qb.pop_front();
        chk("qmode_b", 32'(qmode_b), 32'(ev));
      end
    end
    if (sc_b) begin armed_b = 1; pend_b = 1; sc_n_b++; end
    else if (armed_b && bdone_b) pend_b = 1;
    if (exp_qb.size() == 0) armed_b = 0;
    if (pix_rd_b) begin
      rd_addr_b.push_back(int'(pix_addr_b));
      rd_cyc_b.push_back(cyc);
      chk("rd_addr_range_b", 32'(pix_addr_b < 8'd1), 32'd1);
    end
    if (fd_b) fd_n_b++;
  end

  // ---------------- driver tasks ----------------
  task automatic push_pixel(input bit which, input logic [23:0] p);
    for (int i = 23; i >= 0; i--) begin
      if (which) exp_qb.push_back({1'b0, p[i]});
      else       exp_qa.push_back({1'b0, p[i]});
    end
  endtask

  task automatic push_low(input bit which);
    if (which) exp_qb.push_back(2'b10);
    else       exp_qa.push_back(2'b10);
  endtask

  task automatic clear_logs();
    rd_addr_a.delete(); rd_cyc_a.delete(); rd_addr_b.delete(); rd_cyc_b.delete();
    sc_n_a = 0; sc_n_b = 0; fd_n_a = 0; fd_n_b = 0;
  endtask

  task automatic pulse_start(input bit which);
    if (which) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_fd(input bit which, input int limit, output int at);
    int n = 0;
    while (!(which ? fd_b : fd_a) && n < limit) begin
      @(negedge clk);
      n++;
    end
    at = cyc;
    chk(which ? "fd_b_timeout" : "fd_a_timeout", 32'(which ? fd_b : fd_a), 32'd1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    exp_qa.delete();
    exp_qb.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t0, at, at2, a0, a1, c0, c1;
    logic [23:0] p0, p1;

    reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
    for (int i = 0; i < 4; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
    clear_logs();

    // Reset, with a start coincident with the last reset cycle.
    repeat (3) @(negedge clk);
    start_a = 1'b1; start_b = 1'b1;
    @(negedge clk);
    reset = 1'b0; start_a = 1'b0; start_b = 1'b0;
    chk("rst_qmode_a", 32'(qmode_a), 32'h2);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_pix_rd_a", 32'(pix_rd_a), 32'd0);
    chk("rst_pix_addr_a", 32'(pix_addr_a), 32'd0);
    chk("rst_startcoding_a", 32'(sc_a), 32'd0);
    chk("rst_frame_done_a", 32'(fd_a), 32'd0);
    chk("rst_qmode_b", 32'(qmode_b), 32'h2);
    repeat (3) @(negedge clk);
    chk("start_with_reset_busy_a", 32'(busy_a), 32'd0);
    chk("start_with_reset_busy_b", 32'(busy_b), 32'd0);
    chk("start_with_reset_rd_a", 32'(rd_addr_a.size()), 32'd0);

    // Frame 1: FF0000, 00000F.
    clear_logs();
    mem_a[0] = 24'hFF0000; mem_a[1] = 24'h00000F;
    push_pixel(0, 24'hFF0000); push_pixel(0, 24'h00000F); push_low(0);
    t0 = cyc;
    pulse_start(0);
    chk("f1_busy_cycle1", 32'(busy_a), 32'd1);
    wait_fd(0, 7000, at);
    chk("f1_frame_len", 32'(at - t0), 32'd6658);
    chk("f1_busy_at_done", 32'(busy_a), 32'd1);
    chk("f1_rd_count", 32'(rd_addr_a.size()), 32'd2);
    a0 = (rd_addr_a.size() > 0) ? rd_addr_a[0] : -1;
    c0 = (rd_cyc_a.size() > 0) ? rd_cyc_a[0] - t0 : -1;
    a1 = (rd_addr_a.size() > 1) ? rd_addr_a[1] : -1;
    c1 = (rd_cyc_a.size() > 1) ? rd_cyc_a[1] - t0 : -1;
    chk("f1_rd0_addr", 32'(a0), 32'd0);
    chk("f1_rd0_cycle", 32'(c0), 32'd1);
    chk("f1_rd1_addr", 32'(a1), 32'd1);
    chk("f1_rd1_in_bit0", 32'(c1 >= 3 && c1 <= 130), 32'd1);
    chk("f1_stream_drained", 32'(exp_qa.size()), 32'd0);
    chk("f1_startcoding_count", 32'(sc_n_a), 32'd1);
    @(negedge clk);
`ifdef NZR_AUTO_REFRESH_EN
    chk("f1_auto_busy", 32'(busy_a), 32'd1);
    chk("f1_auto_rd", 32'(pix_rd_a), 32'd1);
    chk("f1_auto_addr", 32'(pix_addr_a), 32'd0);
    wait_fd(0, 7000, at2);
    chk("f1_auto_period", 32'(at2 - at), 32'd6658);
    pulse_reset();
`else
    chk("f1_idle_busy", 32'(busy_a), 32'd0);
    chk("f1_idle_qmode", 32'(qmode_a), 32'h2);
    at2 = at;
`endif

    // Frame 2: random pixels, start pulse during bit 10 is ignored.
    clear_logs();
    p0 = 24'($urandom_range(0, 32'hFFFFFF));
    p1 = 24'($urandom_range(0, 32'hFFFFFF));
    mem_a[0] = p0; mem_a[1] = p1;
    push_pixel(0, p0); push_pixel(0, p1); push_low(0);
    t0 = cyc;
    pulse_start(0);
    repeat (3 + 10 * 128 + 5 - 1) @(negedge clk);
    pulse_start(0);
    wait_fd(0, 7000, at);
    chk("f2_frame_len", 32'(at - t0), 32'd6658);
    chk("f2_startcoding_count", 32'(sc_n_a), 32'd1);
    chk("f2_rd_count", 32'(rd_addr_a.size()), 32'd2);
    chk("f2_stream_drained", 32'(exp_qa.size()), 32'd0);
`ifdef NZR_AUTO_REFRESH_EN
    pulse_reset();
`else
    repeat (2) @(negedge clk);
`endif

    // Frame 3: reset during bit 30 aborts the frame.
    clear_logs();
    p0 = 24'($urandom_range(0, 32'hFFFFFF));
    mem_a[0] = p0; mem_a[1] = ~p0;
    push_pixel(0, p0); push_pixel(0, ~p0); push_low(0);
    pulse_start(0);
    repeat (3 + 30 * 128 + 20 - 1) @(negedge clk);
    reset = 1'b1;
    exp_qa.delete();
    @(negedge clk);
    reset = 1'b0;
    chk("abort_qmode", 32'(qmode_a), 32'h2);
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_pix_rd", 32'(pix_rd_a), 32'd0);
    repeat (7000) @(negedge clk);
    chk("abort_no_frame_done", 32'(fd_n_a), 32'd0);
    chk("abort_qmode_held", 32'(qmode_a), 32'h2);
    chk("abort_busy_held", 32'(busy_a), 32'd0);

    // Single-pixel chain: 800001.
    clear_logs();
    mem_b[0] = 24'h800001;
    push_pixel(1, 24'h800001); push_low(1);
    t0 = cyc;
    pulse_start(1);
    wait_fd(1, 4000, at);
    chk("b_frame_len", 32'(at - t0), 32'd3586);
    chk("b_rd_count", 32'(rd_addr_b.size()), 32'd1);
    a0 = (rd_addr_b.size() > 0) ? rd_addr_b[0] : -1;
    chk("b_rd_addr", 32'(a0), 32'd0);
    chk("b_stream_drained", 32'(exp_qb.size()), 32'd0);
    @(negedge clk);
`ifdef NZR_AUTO_REFRESH_EN
    chk("b_auto_busy", 32'(busy_b), 32'd1);
    pulse_reset();
`else
    chk("b_idle_busy", 32'(busy_b), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
